// File: rtl/xor_crypt_sequencer_pkg.sv
// Shared types and defaults for the XOR-cipher sequencer.
package xor_crypt_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY  = 3'd1,
    ST_MSG  = 3'd2,
    ST_ENC  = 3'd3,
    ST_SEND = 3'd4,
    ST_DONE = 3'd5
  } seq_state_e;

  localparam int DEF_MSG_SIZE = 64;
  localparam int DEF_KEY_SIZE = 8;
  localparam int DEF_TIMEOUT  = 255;

  // Bit counter width; one spare bit so the terminal count always fits.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/xor_crypt_sequencer_watchdog.sv
// Wait-state watchdog: counts cycles while run is high, clears on clr,
// freezes with ena low. expire flags the TIMEOUT-th cycle of the wait.
module seq_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q;

  // Cycle counter; clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (ena) begin
      if (clr)      cnt_q <= '0;
      else if (run) cnt_q <= cnt_q + TW'(1);
    end
  end

  // First wait cycle sees 0, so count TIMEOUT-1 is the last allowed cycle.
  assign expire = run && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/xor_crypt_sequencer.sv
// Sequencer for the serial XOR-cipher datapath: loads key and message
// deserializers, kicks the encrypt stage and the ciphertext serializer,
// with key reuse, abort and a watchdog on the encrypt/send waits.
module xor_crypt_sequencer
  import xor_crypt_sequencer_pkg::*;
#(
  parameter int MSG_SIZE = DEF_MSG_SIZE,
  parameter int KEY_SIZE = DEF_KEY_SIZE,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       iStart,
  input  logic       iKey_reload,
  input  logic       iAbort,
  input  logic       iData_valid,
  input  logic       iData_in,
  input  logic       iEnc_done,
  input  logic       iSer_done,
  output logic       oData_out,
  output logic       oKey_flag,
  output logic       oMsg_flag,
  output logic       oEnc_start,
  output logic       oSer_start,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic       oKey_valid,
  output logic [2:0] oState
);

  localparam int CW = cnt_w(MSG_SIZE);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          key_valid_q, key_valid_d;
  logic          error_q, error_d;
  logic          key_flag_q, key_flag_d;
  logic          msg_flag_q, msg_flag_d;
  logic          enc_start_q, enc_start_d;
  logic          ser_start_q, ser_start_d;
  logic          data_q;
  logic          wd_run, wd_clr, wd_expire;

  // Next-state and next-register values; abort overrides everything but reset.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    key_valid_d = key_valid_q;
    error_d     = error_q;
    key_flag_d  = 1'b0;
    msg_flag_d  = 1'b0;
    enc_start_d = 1'b0;
    ser_start_d = 1'b0;
    if (iAbort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      // A half-shifted key is garbage; a key loaded earlier survives.
      if (state_q == ST_KEY) key_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (iStart) begin
          error_d   = 1'b0;
          bit_cnt_d = '0;
          state_d   = (iKey_reload || !key_valid_q) ? ST_KEY : ST_MSG;
        end
        ST_KEY: if (iData_valid) begin
          key_flag_d = 1'b1;
          if (bit_cnt_q == CW'(KEY_SIZE - 1)) begin
            key_valid_d = 1'b1;
            bit_cnt_d   = '0;
            state_d     = ST_MSG;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        ST_MSG: if (iData_valid) begin
          msg_flag_d = 1'b1;
          if (bit_cnt_q == CW'(MSG_SIZE - 1)) begin
            bit_cnt_d   = '0;
            enc_start_d = 1'b1;
            state_d     = ST_ENC;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        // Completion beats a coincident watchdog expiry.
        ST_ENC: begin
          if (iEnc_done) begin
            ser_start_d = 1'b1;
            state_d     = ST_SEND;
          end else if (wd_expire) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_SEND: begin
          if (iSer_done)      state_d = ST_DONE;
          else if (wd_expire) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign wd_run = (state_q == ST_ENC) || (state_q == ST_SEND);
  assign wd_clr = (state_d != state_q);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .clr    (wd_clr),
    .run    (wd_run),
    .expire (wd_expire)
  );

  // State and flag registers; ena low freezes everything so pulses survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      error_q     <= 1'b0;
      key_flag_q  <= 1'b0;
      msg_flag_q  <= 1'b0;
      enc_start_q <= 1'b0;
      ser_start_q <= 1'b0;
      data_q      <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      key_valid_q <= key_valid_d;
      error_q     <= error_d;
      key_flag_q  <= key_flag_d;
      msg_flag_q  <= msg_flag_d;
      enc_start_q <= enc_start_d;
      ser_start_q <= ser_start_d;
      data_q      <= iData_in;
    end
  end

  // Strobes are masked while frozen and reappear once ena returns.
  assign oKey_flag  = key_flag_q  & ena;
  assign oMsg_flag  = msg_flag_q  & ena;
  assign oEnc_start = enc_start_q & ena;
  assign oSer_start = ser_start_q & ena;
  assign oDone      = (state_q == ST_DONE) & ena;
  assign oData_out  = data_q;
  assign oBusy      = (state_q != ST_IDLE);
  assign oError     = error_q;
  assign oKey_valid = key_valid_q;
  assign oState     = state_q;

endmodule

// File: tb/tb_xor_crypt_sequencer.sv
// Randomized bench: drives whole transactions and compares what the
// sequencer emits against a transaction-level expectation.
module tb_xor_crypt_sequencer;

  localparam int MSG = 64;
  localparam int KEY = 8;
  localparam int TO  = 255;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic iStart = 1'b0, iKey_reload = 1'b0, iAbort = 1'b0;
  logic iData_valid = 1'b0, iData_in = 1'b0, iEnc_done = 1'b0, iSer_done = 1'b0;
  logic oData_out, oKey_flag, oMsg_flag, oEnc_start, oSer_start;
  logic oBusy, oDone, oError, oKey_valid;
  logic [2:0] oState;

  int n_vec = 0, n_err = 0;
  bit m_kv = 1'b0;                       // model: a full key is held
  bit exp_key[$], exp_msg[$], got_key[$], got_msg[$];
  int enc_cnt = 0, ser_cnt = 0, done_cnt = 0;

  xor_crypt_sequencer #(.MSG_SIZE(MSG), .KEY_SIZE(KEY), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .iStart(iStart), .iKey_reload(iKey_reload),
    .iAbort(iAbort), .iData_valid(iData_valid), .iData_in(iData_in),
    .iEnc_done(iEnc_done), .iSer_done(iSer_done), .oData_out(oData_out),
    .oKey_flag(oKey_flag), .oMsg_flag(oMsg_flag), .oEnc_start(oEnc_start),
    .oSer_start(oSer_start), .oBusy(oBusy), .oDone(oDone), .oError(oError),
    .oKey_valid(oKey_valid), .oState(oState)
  );

  always #5 clk = ~clk;

  // Capture what the datapath would see: bits shifted under each flag.
  always @(negedge clk) begin
    if (oKey_flag) got_key.push_back(oData_out);
    if (oMsg_flag) got_msg.push_back(oData_out);
    if (oEnc_start) enc_cnt++;
    if (oSer_start) ser_cnt++;
    if (oDone) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    exp_key.delete(); exp_msg.delete(); got_key.delete(); got_msg.delete();
    enc_cnt = 0; ser_cnt = 0; done_cnt = 0;
  endtask

  // Start a transaction; the model decides whether a key load is due.
  task automatic start(input bit reload, output int nkey);
    clr_mon();
    nkey = (reload || !m_kv) ? KEY : 0;
    iStart = 1'b1; iKey_reload = reload; tick();
    iStart = 1'b0; iKey_reload = 1'b0;
  endtask

  // Stream key then message bits. mode 0: dense, 1: 1/0 toggle, 2: random gaps.
  task automatic stream(input int nkey, input int mode, input int freeze_at, input int abort_at);
    int sent = 0, cyc = 0;
    bit v, d, froze = 1'b0;
    while (sent < nkey + MSG) begin
      if (sent == abort_at) begin
        iData_valid = 1'b0; iAbort = 1'b1; tick(); iAbort = 1'b0;
        return;
      end
      if (sent == freeze_at && !froze) begin
        froze = 1'b1;
        for (int i = 0; i < 10; i++) begin
          ena = 1'b0;
          iData_valid = 1'($urandom_range(0, 1)); iData_in = 1'($urandom_range(0, 1));
          tick();
          chk("freeze_no_flag", {oKey_flag, oMsg_flag}, 2'b00);
          chk("freeze_state", oState, 3'd2);
        end
        ena = 1'b1;
      end
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      iData_valid = v; iData_in = d;
      if (v) begin
        if (sent < nkey) exp_key.push_back(d); else exp_msg.push_back(d);
        sent++;
      end
      tick(); cyc++;
    end
    iData_valid = 1'b0;
  endtask

  // Encrypt/send handshake; either expect a timeout or stop with reset in SEND.
  task automatic finish(input int enc_dly, input int ser_dly, input bit to, input bit rst_send);
    int k;
    for (k = 0; k < 20; k++) begin @(negedge clk); if (oEnc_start) break; end
    chk("enc_start_lat", k, 0);
    if (to) begin
      for (k = 1; k < 400; k++) begin @(negedge clk); if (oError) break; end
      chk("timeout_cycles", k, TO);
      chk("timeout_state", oState, 3'd0);
      return;
    end
    repeat (enc_dly) @(posedge clk);
    #1 iEnc_done = 1'b1; tick(); iEnc_done = 1'b0;
    for (k = 0; k < 20; k++) begin @(negedge clk); if (oSer_start) break; end
    chk("ser_start_lat", k, 0);
    if (rst_send) begin
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("async_reset_outs", {oData_out, oKey_flag, oMsg_flag, oEnc_start, oSer_start,
                                  oBusy, oDone, oError, oKey_valid, oState}, 0);
      m_kv = 1'b0;
      #2 rst_n = 1'b1; tick();
      return;
    end
    repeat (ser_dly) @(posedge clk);
    #1 iSer_done = 1'b1; tick(); iSer_done = 1'b0;
    for (k = 0; k < 20; k++) begin @(negedge clk); if (oDone) break; end
    chk("done_lat", k, 0);
    @(negedge clk);
    chk("idle_after_done", {oBusy, oDone}, 2'b00);
    m_kv = 1'b1;
  endtask

  task automatic cmp_bits(input string nm);
    chk({nm, "_key_cnt"}, got_key.size(), exp_key.size());
    chk({nm, "_msg_cnt"}, got_msg.size(), exp_msg.size());
    for (int i = 0; i < exp_key.size() && i < got_key.size(); i++)
      chk({nm, "_key_bit"}, got_key[i], exp_key[i]);
    for (int i = 0; i < exp_msg.size() && i < got_msg.size(); i++)
      chk({nm, "_msg_bit"}, got_msg[i], exp_msg[i]);
  endtask

  task automatic cmp_run(input string nm, input int nkey);
    cmp_bits(nm);
    chk({nm, "_key_flags"}, got_key.size(), nkey);
    chk({nm, "_msg_flags"}, got_msg.size(), MSG);
    chk({nm, "_enc_pulses"}, enc_cnt, 1);
    chk({nm, "_ser_pulses"}, ser_cnt, 1);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_key_valid"}, oKey_valid, m_kv);
  endtask

  initial begin
    int nk;
    #12;
    chk("reset_outs", {oData_out, oKey_flag, oMsg_flag, oEnc_start, oSer_start,
                       oBusy, oDone, oError, oKey_valid, oState}, 0);
    rst_n = 1'b1; tick();

    // Full run from an empty key.
    start(1'b0, nk); chk("full_nkey", nk, KEY);
    stream(nk, 0, -1, -1); finish(3, 70, 1'b0, 1'b0); cmp_run("full", nk);

    // Key reuse, then a forced reload.
    start(1'b0, nk); stream(nk, 2, -1, -1); finish(1, 5, 1'b0, 1'b0); cmp_run("reuse", nk);
    chk("reuse_nkey", nk, 0);
    start(1'b1, nk); stream(nk, 2, -1, -1); finish(2, 3, 1'b0, 1'b0); cmp_run("reload", nk);

    // Alternating valid.
    start(1'b0, nk); stream(nk, 1, -1, -1); finish(4, 9, 1'b0, 1'b0); cmp_run("gapped", nk);

    // Ten-cycle freeze mid-message.
    start(1'b0, nk); stream(nk, 2, 20, -1); finish(2, 7, 1'b0, 1'b0); cmp_run("freeze", nk);

    // Encrypt never completes.
    start(1'b0, nk); stream(nk, 0, -1, -1); finish(0, 0, 1'b1, 1'b0);
    chk("timeout_err", oError, 1'b1);
    chk("timeout_kv", oKey_valid, 1'b1);
    tick();

    // Next start clears the error; abort at message bit 30 keeps the key.
    start(1'b0, nk);
    chk("start_clears_err", oError, 1'b0);
    stream(nk, 0, -1, 30);
    chk("abort_msg_state", oState, 3'd0);
    chk("abort_msg_kv", oKey_valid, 1'b1);
    repeat (3) tick();
    chk("abort_msg_nodone", done_cnt, 0);
    chk("abort_msg_bits", got_msg.size(), 30);
    cmp_bits("abort_msg");

    // Abort at key bit 4 loses the key.
    start(1'b1, nk); stream(nk, 0, -1, 4);
    chk("abort_key_state", oState, 3'd0);
    chk("abort_key_kv", oKey_valid, 1'b0);
    m_kv = 1'b0;
    tick();
    chk("abort_key_bits", got_key.size(), 4);

    // Random transactions.
    for (int r = 0; r < 4; r++) begin
      start(1'($urandom_range(0, 1)), nk);
      stream(nk, 2, -1, -1);
      finish($urandom_range(0, 20), $urandom_range(0, 80), 1'b0, 1'b0);
      cmp_run("rand", nk);
    end

    // Reset in the middle of SEND.
    start(1'b0, nk); stream(nk, 2, -1, -1); finish(2, 0, 1'b0, 1'b1);
    chk("post_reset_kv", oKey_valid, 1'b0);
    chk("post_reset_state", oState, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
